// File: rtl/wishbone_arbiter.sv
// Two-requester Wishbone round-robin arbiter. Setting the macro WB_ARB_TIMEOUT_EN
// adds an ack-wait watchdog that ends a stalled grant with a bus error.
module wishbone_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t state, state_nxt;
  logic   last_owner;
  logic   timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GRANT0)      last_owner <= 1'b0;
      else if (state == IDLE && state_nxt == GRANT1) last_owner <= 1'b1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;
  logic          sel_stb;

  assign sel_stb = (state == GRANT0 && m0_stb_i) || (state == GRANT1 && m1_stb_i);
  // An ack in the terminal cycle wins over the forced error.
  assign timeout = (state != IDLE) && (tcnt == CW'(TIMEOUT_CYCLES)) && !ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE || state_nxt == IDLE || ack_i) tcnt <= '0;
    else if (sel_stb)                                          tcnt <= tcnt + CW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_o   = 2'b00;
    cyc_o     = 1'b0;
    stb_o     = 1'b0;
    we_o      = 1'b0;
    adr_o     = '0;
    dat_o     = '0;
    m0_dat_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_owner ? GRANT0 : GRANT1;
        else if (m0_cyc_i)        state_nxt = GRANT0;
        else if (m1_cyc_i)        state_nxt = GRANT1;
      end
      GRANT0: begin
        grant_o  = 2'b01;
        m0_err_o = timeout;
        if (!m0_cyc_i || timeout) state_nxt = IDLE;
        if (!timeout) begin
          cyc_o    = m0_cyc_i;
          stb_o    = m0_stb_i;
          we_o     = m0_we_i;
          adr_o    = m0_adr_i;
          dat_o    = m0_dat_i;
          m0_ack_o = ack_i;
          m0_dat_o = dat_i;
        end
      end
      GRANT1: begin
        grant_o  = 2'b10;
        m1_err_o = timeout;
        if (!m1_cyc_i || timeout) state_nxt = IDLE;
        if (!timeout) begin
          cyc_o    = m1_cyc_i;
          stb_o    = m1_stb_i;
          we_o     = m1_we_i;
          adr_o    = m1_adr_i;
          dat_o    = m1_dat_i;
          m1_ack_o = ack_i;
          m1_dat_o = dat_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed + randomized bench for wishbone_arbiter against a cycle-level
// ownership model; timeout scenarios run only when WB_ARB_TIMEOUT_EN is defined.
module tb_wishbone_arbiter;
  localparam int TOC = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat;
  logic        ack;
  logic [31:0] m0_dat, m1_dat, adr_o, dat_o;
  logic        m0_ack, m1_ack, m0_err, m1_err, cyc_o, stb_o, we_o;
  logic [1:0]  grant;

  wishbone_arbiter #(.TIMEOUT_CYCLES(TOC)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]),
    .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]),
    .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(rdat), .ack_i(ack), .grant_o(grant)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;
  // Model: owner 0/1 = granted requester, 2 = idle
  int owner = 2, last = 1, cnt = 0;
  int ack0_cnt = 0, ack1_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    bit to, on;
    int n;
    logic [1:0] eg;
    to = TO_EN && owner < 2 && cnt == TOC && !ack;
    on = owner < 2 && !to;
    n  = (owner < 2) ? owner : 0;
    eg = 2'b00;
    if (owner < 2) eg[n] = 1'b1;
    chk("grant", grant, eg);
    chk("cyc_o", cyc_o, on ? cyc[n] : 1'b0);
    chk("stb_o", stb_o, on ? stb[n] : 1'b0);
    chk("we_o",  we_o,  on ? we[n]  : 1'b0);
    chk("adr_o", adr_o, on ? adr[n]  : 32'h0);
    chk("dat_o", dat_o, on ? wdat[n] : 32'h0);
    chk("m0_ack", m0_ack, (on && n == 0) ? ack : 1'b0);
    chk("m1_ack", m1_ack, (on && n == 1) ? ack : 1'b0);
    chk("m0_dat", m0_dat, (on && n == 0) ? rdat : 32'h0);
    chk("m1_dat", m1_dat, (on && n == 1) ? rdat : 32'h0);
    chk("m0_err", m0_err, to && n == 0);
    chk("m1_err", m1_err, to && n == 1);
  endtask

  // Settle, check against the model, advance the model across one clock edge.
  task automatic tick();
    bit to;
    #1;
    check_model();
    ack0_cnt += int'(m0_ack);
    ack1_cnt += int'(m1_ack);
    to = TO_EN && owner < 2 && cnt == TOC && !ack;
    if (rst) begin
      owner = 2; last = 1; cnt = 0;
    end else if (owner == 2) begin
      if (cyc == 2'b11)  owner = 1 - last;
      else if (cyc[0])   owner = 0;
      else if (cyc[1])   owner = 1;
      if (owner < 2) last = owner;
      cnt = 0;
    end else if (to || !cyc[owner]) begin
      owner = 2; cnt = 0;
    end else if (ack) cnt = 0;
    else if (stb[owner]) cnt++;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] r33 [10];
  bit acked;

  initial begin
    r33 = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    rst = 1'b1; cyc = '0; stb = '0; we = '0; ack = 1'b0; rdat = '0;
    for (int i = 0; i < 2; i++) begin adr[i] = '0; wdat[i] = '0; end
    @(posedge clk); #1;
    tick();                       // reset state
    rst = 1'b0;

    // single requester, ack on third granted cycle
    cyc = 2'b01; stb = 2'b01; adr[0] = 32'h100; wdat[0] = 32'hCAFE_0001;
    ack0_cnt = 0; ack1_cnt = 0;
    tick();
    #1 chk("r31_grant", grant, 2'b01); chk("r31_adr", adr_o, 32'h100);
    tick(); tick();
    ack = 1'b1; rdat = $urandom;
    tick();
    ack = 1'b0; cyc = 2'b00; stb = 2'b00;
    tick(); tick();
    chk("r31_m0_acks", ack0_cnt, 1);
    chk("r31_m1_acks", ack1_cnt, 0);

    // simultaneous requests after reset: m0 first, one idle cycle, then m1
    rst = 1'b1; tick(); rst = 1'b0;
    cyc = 2'b11; stb = 2'b11; adr[0] = 32'hA0; adr[1] = 32'hB0;
    tick();
    #1 chk("r32_first", grant, 2'b01);
    tick();
    cyc = 2'b10;
    tick();
    #1 chk("r32_gap", grant, 2'b00);
    tick();
    #1 chk("r32_second", grant, 2'b10); chk("r32_adr", adr_o, 32'hB0);
    cyc = 2'b00; stb = 2'b00;
    tick(); tick();

    // continuous contention, one ack per tenure
    acked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (owner == 2) begin cyc = 2'b11; stb = 2'b11; ack = 1'b0; acked = 1'b0; end
      else if (!acked) begin ack = 1'b1; acked = 1'b1; end
      else begin ack = 1'b0; cyc[owner] = 1'b0; end
      #1 chk($sformatf("r33_g%0d", i), grant, r33[i]);
      tick();
    end
    cyc = 2'b00; stb = 2'b00; ack = 1'b0;
    tick(); tick();

    // reset mid-transfer in GRANT1, then m0 wins contention
    cyc = 2'b10; stb = 2'b10; adr[1] = 32'h1234;
    tick(); tick();
    rst = 1'b1;
    tick();
    #1 chk("r36_grant", grant, 2'b00); chk("r36_cyc", cyc_o, 1'b0); chk("r36_adr", adr_o, 32'h0);
    rst = 1'b0; cyc = 2'b11; stb = 2'b11;
    tick();
    #1 chk("r36_m0_wins", grant, 2'b01);
    cyc = 2'b00; stb = 2'b00;
    tick(); tick();

`ifdef WB_ARB_TIMEOUT_EN
    // m1 stalls: error after TOC stalled cycles, then re-grant
    cyc = 2'b10; stb = 2'b10; ack = 1'b0;
    tick();
    for (int k = 0; k < TOC; k++) begin
      #1 chk("to_stall_err", m1_err, 1'b0); chk("to_stall_cyc", cyc_o, 1'b1);
      tick();
    end
    #1 chk("to_err", m1_err, 1'b1); chk("to_cyc", cyc_o, 1'b0); chk("to_ack", m1_ack, 1'b0);
    tick();
    #1 chk("to_idle", grant, 2'b00); chk("to_err_once", m1_err, 1'b0);
    tick();
    #1 chk("to_regrant", grant, 2'b10);
    for (int k = 0; k < TOC; k++) tick();
    ack = 1'b1;
    #1 chk("to_ackwin_ack", m1_ack, 1'b1); chk("to_ackwin_err", m1_err, 1'b0);
    chk("to_ackwin_cyc", cyc_o, 1'b1);
    tick();
    ack = 1'b0; cyc = 2'b00; stb = 2'b00;
    tick(); tick();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        if (cyc[i]) begin
          if ($urandom_range(0, 7) == 0) cyc[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) cyc[i] = 1'b1;
        stb[i]  = ($urandom_range(0, 3) != 0);
        we[i]   = 1'($urandom_range(0, 1));
        adr[i]  = $urandom;
        wdat[i] = $urandom;
      end
      rdat = $urandom;
      ack  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the ack-wait cycles before a forced bus-error termination; it is used only with WB_ARB_TIMEOUT_EN.
REQ-002 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 mN_cyc_i (N=0,1)  in  1  SHALL be requester N's bus-cycle request.
REQ-005 mN_stb_i  in  1  SHALL be requester N's strobe.
REQ-006 mN_we_i  in  1  SHALL be requester N's write enable.
REQ-007 mN_adr_i  in  32  SHALL be requester N's address.
REQ-008 mN_dat_i  in  32  SHALL be requester N's write data.
REQ-009 mN_dat_o  out  32  SHALL carry read data to requester N.
REQ-010 mN_ack_o  out  1  SHALL be the acknowledge to requester N.
REQ-011 mN_err_o  out  1  SHALL be the timeout error to requester N.
REQ-012 cyc_o, stb_o, we_o  out  1 each  SHALL be the shared-bus cycle, strobe and write enable.
REQ-013 adr_o, dat_o  out  32 each  SHALL be the shared-bus address and write data.
REQ-014 dat_i  in  32  SHALL be the shared-bus read data.
REQ-015 ack_i  in  1  SHALL be the shared-bus acknowledge.
REQ-016 grant_o  out  2  SHALL be one-hot current owner; 2'b00 when idle.

Function
REQ-017 FSM states SHALL be IDLE, GRANT0, GRANT1; a last_owner register SHALL drive round-robin.
REQ-018 In IDLE: only m0_cyc_i high -> GRANT0 next edge; only m1_cyc_i high -> GRANT1; both high -> the requester other than last_owner; neither -> stay IDLE.
REQ-019 Entering GRANTn SHALL set last_owner to n.
REQ-020 GRANTn SHALL hold while mn_cyc_i is high; mn_cyc_i low -> IDLE next edge, giving exactly one idle cycle between owners.
REQ-021 In GRANTn, cyc_o, stb_o, we_o, adr_o, dat_o SHALL combinationally follow requester n's inputs; in IDLE all SHALL be 0.
REQ-022 In GRANTn, mn_ack_o SHALL equal ack_i and mn_dat_o SHALL equal dat_i; the non-owner SHALL see ack 0 and dat 0.
REQ-023 A requester changing inputs while not granted SHALL have no effect on bus outputs.
REQ-024 An ack_i arriving while IDLE SHALL be ignored and not forwarded.

Reset
REQ-025 rst_i high SHALL force IDLE, last_owner=1 (m0 wins first contention), timeout counter 0, and every output 0 on the next edge, including mid-transfer.

Configuration
REQ-026 With macro WB_ARB_TIMEOUT_EN defined, a counter SHALL increment each GRANTn cycle with stb_o=1 and ack_i=0, and clear on ack_i=1 or on leaving GRANTn.
REQ-027 With WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, mn_err_o SHALL pulse one cycle, bus outputs SHALL drop to 0 that cycle, and the FSM SHALL go to IDLE.
REQ-028 ack_i=1 in the cycle the counter reaches TIMEOUT_CYCLES SHALL win: ack forwarded, no err.
REQ-029 After a timeout, normal arbitration SHALL resume, so a requester still holding cyc SHALL be re-granted per round-robin.
REQ-030 Without WB_ARB_TIMEOUT_EN, no counter SHALL exist, mN_err_o SHALL be constant 0, and a grant SHALL wait indefinitely for ack_i.

Verification
REQ-031 After reset, m0 requests alone, adr 0x100, ack_i on 3rd cycle -> grant_o=01, adr_o=0x100, m0_ack_o pulses once, m1_ack_o stays 0.
REQ-032 m0 and m1 request in the same cycle after reset -> GRANT0 first; m0 drops cyc -> one IDLE cycle, then grant_o=10.
REQ-033 Both request continuously, each drops cyc after one ack -> grants alternate 01,00,10,00,01.
REQ-034 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, m1 granted, ack_i never -> m1_err_o pulses once after 4 stalled cycles, cyc_o=0 that cycle.
REQ-035 WB_ARB_TIMEOUT_EN, ack_i coincides with 4th stalled cycle -> m1_ack_o=1, m1_err_o=0.
REQ-036 rst_i asserted mid-transfer in GRANT1 -> next edge grant_o=00, cyc_o=0, all outputs 0; the next contention is won by m0.
